// File: rtl/aes_cmd_ctrl.sv
// Command front-end for aes_state: accepts key-load/encrypt/decrypt requests, sequences one
// enable pulse per command, and returns a buffered result/status with a WAIT watchdog.
module aes_cmd_ctrl #(
  parameter int unsigned NK      = 8,
  parameter int unsigned NB      = 4,
  parameter int unsigned KEY_W   = 32 * NK,
  parameter int unsigned DATA_W  = 32 * NB,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [DATA_W-1:0] req_data,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              key_loaded,
  // aes_state interface (aes_in / aes_out fields)
  output logic              aes_in_enable,
  output logic [1:0]        aes_in_func,
  output logic [KEY_W-1:0]  aes_in_key,
  output logic [DATA_W-1:0] aes_in_data,
  input  logic [DATA_W-1:0] aes_out_result,
  input  logic              aes_out_ready
);

  localparam logic [1:0] OpIllegal  = 2'd0;
  localparam logic [1:0] OpKey      = 2'd1;
  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrNoKey   = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrIllegal = 2'd3;

  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                key_loaded_q, key_loaded_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    data_d       = data_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    key_loaded_d = key_loaded_q;
    wdog_d       = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d   = req_op;
          key_d  = req_key;
          data_d = req_data;
          wdog_d = '0;
          if (req_op == OpIllegal) begin
            rsp_data_d = '0;
            rsp_err_d  = ErrIllegal;
            state_d    = StResp;
          end else if (req_op != OpKey && !key_loaded_q) begin
            // Cipher op without a key: answer directly, aes_state is never enabled.
            rsp_data_d = '0;
            rsp_err_d  = ErrNoKey;
            state_d    = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (op_q == OpKey) key_loaded_d = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over the watchdog expiring in the same cycle.
        if (aes_out_ready) begin
          rsp_data_d = (op_q == OpKey) ? '0 : aes_out_result;
          rsp_err_d  = ErrOk;
          if (op_q == OpKey) key_loaded_d = 1'b1;
          state_d = StResp;
        end else if (wdog_q == WdogLast) begin
          rsp_data_d = '0;
          rsp_err_d  = ErrTimeout;
          wdog_d     = '0;
          state_d    = StResp;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= 2'd0;
      key_q        <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 2'd0;
      key_loaded_q <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      data_q       <= data_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      key_loaded_q <= key_loaded_d;
      wdog_q       <= wdog_d;
    end
  end

  // req_ready is gated by rst so it drops in the same cycle reset is asserted.
  assign req_ready     = (state_q == StIdle) && !rst;
  assign rsp_valid     = (state_q == StResp);
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign key_loaded    = key_loaded_q;
  assign aes_in_enable = (state_q == StIssue);
  assign aes_in_func   = op_q;
  assign aes_in_key    = key_q;
  assign aes_in_data   = data_q;

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// Scoreboard bench for aes_cmd_ctrl with a behavioural aes_state stub that returns known
// FIPS-197 AES-256 vectors.
module tb_aes_cmd_ctrl;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [255:0] req_key;
  logic [127:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_err;
  logic         key_loaded;
  logic         aes_in_enable;
  logic [1:0]   aes_in_func;
  logic [255:0] aes_in_key;
  logic [127:0] aes_in_data;
  logic [127:0] aes_out_result;
  logic         aes_out_ready;

  aes_cmd_ctrl #(.TIMEOUT(16), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .key_loaded(key_loaded),
    .aes_in_enable(aes_in_enable), .aes_in_func(aes_in_func),
    .aes_in_key(aes_in_key), .aes_in_data(aes_in_data),
    .aes_out_result(aes_out_result), .aes_out_ready(aes_out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int lat = 0;
  int sent_cnt = 0;
  int done_cnt = 0;
  int enable_cnt = 0;
  int stub_delay = 2;
  bit stub_hang = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // aes_state stub: answers a known vector a few cycles after the enable pulse.
  initial begin
    int cnt;
    logic [1:0]   cap_func;
    logic [255:0] cap_key;
    logic [127:0] cap_data;
    cnt = -1;
    aes_out_ready  = 1'b0;
    aes_out_result = '0;
    forever begin
      @(negedge clk);
      aes_out_ready = 1'b0;
      if (rst) begin
        cnt = -1;
      end else begin
        if (cnt == 0) begin
          chk("op_func_held", {254'd0, aes_in_func}, {254'd0, cap_func});
          chk("op_key_held", aes_in_key, cap_key);
          chk("op_data_held", {128'd0, aes_in_data}, {128'd0, cap_data});
          aes_out_ready = 1'b1;
          if (aes_in_func == 2'd2 && aes_in_key == KEY && aes_in_data == PT)
            aes_out_result = CT;
          else if (aes_in_func == 2'd3 && aes_in_key == KEY && aes_in_data == CT)
            aes_out_result = PT;
          else
            aes_out_result = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
          cnt = -1;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (aes_in_enable) begin
          enable_cnt++;
          cap_func = aes_in_func;
          cap_key  = aes_in_key;
          cap_data = aes_in_data;
          cnt = stub_hang ? -1 : stub_delay;
        end
      end
    end
  end

  // Response monitor: compares every presented response against the queue head.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat = cyc - acc_cyc;
        end
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {255'd0, rsp_valid}, 256'd0);
        end else begin
          chk("rsp_data", {128'd0, rsp_data}, {128'd0, exp_q[0].data});
          chk("rsp_err", {254'd0, rsp_err}, {254'd0, exp_q[0].err});
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            done_cnt++;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [255:0] key, input logic [127:0] data,
                      input bit push, input logic [127:0] ed, input logic [1:0] ee);
    exp_t e;
    bit ok;
    @(posedge clk);
    #1;
    if (push) begin
      e.data = ed;
      e.err  = ee;
      exp_q.push_back(e);
      sent_cnt++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 256'd0, 256'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_all();
    for (int i = 0; i < 300 && done_cnt != sent_cnt; i++) @(negedge clk);
    chk("drain", done_cnt, sent_cnt);
  endtask

  initial begin
    int en0;
    bit got;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_key = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {255'd0, req_ready}, 256'd0);
    chk("rst_rsp_valid", {255'd0, rsp_valid}, 256'd0);
    chk("rst_outputs", {rsp_data, rsp_err, key_loaded, aes_in_enable, aes_in_func}, 256'd0);
    chk("rst_aes_key", aes_in_key, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {255'd0, req_ready}, 256'd1);

    // ENC before any key: NOKEY, one-cycle latency, no enable.
    en0 = enable_cnt;
    send(2'd2, KEY, PT, 1'b1, 128'd0, 2'd1);
    wait_all();
    chk("nokey_lat", lat, 1);
    chk("nokey_no_enable", enable_cnt - en0, 0);

    // Illegal op.
    send(2'd0, KEY, PT, 1'b1, 128'd0, 2'd3);
    wait_all();
    chk("illegal_lat", lat, 1);

    // Key load: data reported as 0, key_loaded rises.
    send(2'd1, KEY, 128'd0, 1'b1, 128'd0, 2'd0);
    wait_all();
    chk("key_lat", lat, 5);
    chk("key_loaded_set", {255'd0, key_loaded}, 256'd1);

    // ENC with response back-pressure while a DEC request waits.
    en0 = enable_cnt;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send(2'd2, KEY, PT, 1'b1, CT, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("enc_rsp_seen", {255'd0, got}, 256'd1);
    chk("enc_lat", lat, 5);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_data  = CT;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_req_ready", {255'd0, req_ready}, 256'd0);
      chk("hold_rsp_valid", {255'd0, rsp_valid}, 256'd1);
    end
    chk("hold_one_enable", enable_cnt - en0, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(2'd3, KEY, CT, 1'b1, PT, 2'd0);
    wait_all();
    chk("dec_key_loaded", {255'd0, key_loaded}, 256'd1);

    // Hung key load times out after 16 WAIT cycles and leaves no key.
    stub_hang = 1'b1;
    send(2'd1, KEY, 128'd0, 1'b1, 128'd0, 2'd2);
    wait_all();
    chk("timeout_lat", lat, 18);
    chk("timeout_key_loaded", {255'd0, key_loaded}, 256'd0);
    stub_hang = 1'b0;
    send(2'd2, KEY, PT, 1'b1, 128'd0, 2'd1);
    wait_all();

    // Reload key, then reset in the middle of a hung ENC.
    send(2'd1, KEY, 128'd0, 1'b1, 128'd0, 2'd0);
    wait_all();
    chk("reload_key_loaded", {255'd0, key_loaded}, 256'd1);
    stub_hang = 1'b1;
    send(2'd2, KEY, PT, 1'b0, 128'd0, 2'd0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", {255'd0, req_ready}, 256'd0);
    chk("midrst_rsp_valid", {255'd0, rsp_valid}, 256'd0);
    chk("midrst_outputs", {rsp_data, rsp_err, key_loaded, aes_in_enable, aes_in_func}, 256'd0);
    chk("midrst_aes_data", {128'd0, aes_in_data}, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stub_hang = 1'b0;
    send(2'd0, 256'd0, 128'd0, 1'b1, 128'd0, 2'd3);
    wait_all();
    send(2'd2, KEY, PT, 1'b1, 128'd0, 2'd1);
    wait_all();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
